uart_rx_stream: RTL and testbench

Parametrised UART receiver, the successor to the fixed 8N1 receiver. Data bits, parity, stop bits and oversampling are configurable. It adds an input synchroniser, error detection, a receive FIFO and a valid/ready pop interface. It sits between the board RX pin and the UART peripheral register block on the system bus.

---
 rtl/uart_rx_stream_pkg.sv | 23 ++
 rtl/uart_rx_stream_if.sv | 23 ++
 rtl/uart_rx_stream_fifo.sv | 58 +++++
 rtl/uart_rx_stream.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_stream.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_stream_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Receiver FSM states, parity modes and FIFO entry sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    PUSH,
    BREAK
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Each FIFO entry carries {frame_err, parity_err, data}.
  function automatic int fifo_entry_w(input int data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/uart_rx_stream_if.sv
// Valid/ready pop interface between the UART receive FIFO and its consumer.
// The receiver drives the head entry and occupancy; the consumer drives ready.
interface uart_rx_stream_if #(
  parameter int DATA_BITS = 8,
  parameter int LVL_W     = 3
);
  logic                 valid;
  logic                 ready;
  logic [DATA_BITS-1:0] data;
  logic                 parity_err;
  logic                 frame_err;
  logic [LVL_W-1:0]     level;

  modport master (
    output valid, data, parity_err, frame_err, level,
    input  ready
  );

  modport slave (
    input  valid, data, parity_err, frame_err, level,
    output ready
  );
endinterface

// File: rtl/uart_rx_stream_fifo.sv
// Synchronous FIFO for received UART frames; head is read combinationally
// from registered storage and forced to zero when empty.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign level_o = level_q;
  assign do_pop  = pop_i && !empty_o;
  // A simultaneous pop frees the slot, so a push while full still lands.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// Parametrised UART receiver with synchroniser, majority sampling, error flags
// and receive FIFO. Optional break detection: define UART_RX_BREAK_DET_EN.
module uart_rx_stream import uart_pkg::*; #(
  parameter int CLK_DIV    = 108,
  parameter int OVERSAMPLE = 4,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rx,
  uart_rx_stream_if.master rx_if,
  output logic             o_overrun,
  input  logic             i_overrun_clr
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic             o_break
`endif
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W    = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(DATA_BITS);
  localparam int ENTRY_W = fifo_entry_w(DATA_BITS);

  logic                 sync1_q, sync2_q;
  logic [DIV_W-1:0]     div_q;
  logic [5:0]           hist_q;
  logic                 tick;
  logic                 sample;
  logic                 start_det;
  logic                 bit_tick;
  logic                 last_stop;
  rx_state_t            state_q;
  logic [PH_W-1:0]      phase_q;
  logic [BIT_W-1:0]     bit_q;
  logic                 stop_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 par_err_q;
  logic                 frm_err_q;
  logic                 overrun_q;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   head;

  assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
  // hist_q[0] is the newest sample; the window below reads oldest first.
  assign sample    = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync2_q) | (hist_q[0] & sync2_q);
  assign start_det = ({hist_q[4:0], sync2_q} == 6'b111000);
  assign bit_tick  = tick && (phase_q == PH_W'(OVERSAMPLE - 1));
  assign last_stop = (stop_q == 1'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      div_q   <= '0;
      hist_q  <= '1;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
      div_q   <= tick ? '0 : div_q + 1'b1;
      if (tick) hist_q <= {hist_q[4:0], sync2_q};
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic ones_q;
  logic break_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q  <= 1'b0;
      break_q <= 1'b0;
    end else begin
      break_q <= 1'b0;
      if (state_q == IDLE) ones_q <= 1'b0;
      else if (bit_tick)   ones_q <= ones_q | sample;
      if (state_q == STOP && bit_tick && last_stop && !(ones_q | sample)) break_q <= 1'b1;
    end
  end

  assign o_break = break_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      data_q    <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick && start_det) begin
            state_q   <= DATA;
            phase_q   <= '0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
          end
        end
        DATA: begin
          if (tick) phase_q <= phase_q + 1'b1;
          if (bit_tick) begin
            data_q <= {sample, data_q[DATA_BITS-1:1]};
            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
              state_q <= (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        uart_pkg::PARITY: begin
          if (tick) phase_q <= phase_q + 1'b1;
          if (bit_tick) begin
            par_err_q <= (((^data_q) ^ sample) != (PARITY == PAR_ODD));
            state_q   <= STOP;
          end
        end
        STOP: begin
          if (tick) phase_q <= phase_q + 1'b1;
          if (bit_tick) begin
            if (!sample) frm_err_q <= 1'b1;
            if (last_stop) begin
`ifdef UART_RX_BREAK_DET_EN
              state_q <= (ones_q | sample) ? PUSH : BREAK;
`else
              state_q <= PUSH;
`endif
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        PUSH:    state_q <= IDLE;
        BREAK:   if (tick && sample) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push = (state_q == PUSH);
  assign pop  = rx_if.ready;

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({frm_err_q, par_err_q, data_q}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (rx_if.level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (push && fifo_full && !(pop && !fifo_empty)) begin
      overrun_q <= 1'b1;
    end else if (i_overrun_clr) begin
      overrun_q <= 1'b0;
    end
  end

  assign o_overrun        = overrun_q;
  assign rx_if.valid      = !fifo_empty;
  assign rx_if.data       = head[DATA_BITS-1:0];
  assign rx_if.parity_err = head[DATA_BITS];
  assign rx_if.frame_err  = head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream: 8N1, even-parity and two-stop-bit instances
// share one clock and reset; each scenario task checks its own expectations.
module tb_uart_rx_stream;

  localparam int CLK_DIV = 8;
  localparam int OS      = 4;
  localparam int BIT_CLK = CLK_DIV * OS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_p = 1'b1, rx_s = 1'b1;
  logic clr_a = 1'b0, clr_p = 1'b0, clr_s = 1'b0;
  logic ovr_a, ovr_p, ovr_s;
  int   checks = 0;
  int   errors = 0;
`ifdef UART_RX_BREAK_DET_EN
  logic brk_a, brk_p, brk_s;
  int   brk_cnt = 0;
  always @(negedge clk) if (brk_a) brk_cnt++;
`endif

  always #5 clk = ~clk;

  uart_rx_stream_if #(.DATA_BITS(8), .LVL_W(3)) if_a ();
  uart_rx_stream_if #(.DATA_BITS(8), .LVL_W(3)) if_p ();
  uart_rx_stream_if #(.DATA_BITS(8), .LVL_W(3)) if_s ();

  uart_rx_stream #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .i_rx(rx_a), .rx_if(if_a), .o_overrun(ovr_a), .i_overrun_clr(clr_a)
`ifdef UART_RX_BREAK_DET_EN
    , .o_break(brk_a)
`endif
  );

  uart_rx_stream #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
    .clk(clk), .rst(rst), .i_rx(rx_p), .rx_if(if_p), .o_overrun(ovr_p), .i_overrun_clr(clr_p)
`ifdef UART_RX_BREAK_DET_EN
    , .o_break(brk_p)
`endif
  );

  uart_rx_stream #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) dut_s (
    .clk(clk), .rst(rst), .i_rx(rx_s), .rx_if(if_s), .o_overrun(ovr_s), .i_overrun_clr(clr_s)
`ifdef UART_RX_BREAK_DET_EN
    , .o_break(brk_s)
`endif
  );

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0:       rx_a = v;
      1:       rx_p = v;
      default: rx_s = v;
    endcase
  endtask

  // Bits go out LSB first; the line keeps the last bit value afterwards.
  task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(sel, bits[i]);
      repeat (BIT_CLK) @(negedge clk);
    end
  endtask

  task automatic idle(input int sel, input int nbits);
    set_line(sel, 1'b1);
    repeat (nbits * BIT_CLK) @(negedge clk);
  endtask

  task automatic pop(input int sel);
    case (sel)
      0: begin
        $display("pop dut_a data=%h perr=%b ferr=%b", if_a.data, if_a.parity_err, if_a.frame_err);
        if_a.ready = 1'b1; @(negedge clk); if_a.ready = 1'b0;
      end
      1: begin
        $display("pop dut_p data=%h perr=%b ferr=%b", if_p.data, if_p.parity_err, if_p.frame_err);
        if_p.ready = 1'b1; @(negedge clk); if_p.ready = 1'b0;
      end
      default: begin
        $display("pop dut_s data=%h perr=%b ferr=%b", if_s.data, if_s.parity_err, if_s.frame_err);
        if_s.ready = 1'b1; @(negedge clk); if_s.ready = 1'b0;
      end
    endcase
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (if_a.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_a.valid); end
    checks++; if (if_a.data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", if_a.data); end
    checks++; if ({if_a.parity_err, if_a.frame_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b exp 00", {if_a.parity_err, if_a.frame_err}); end
    checks++; if (if_a.level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", if_a.level); end
    checks++; if ({ovr_a, ovr_p, ovr_s} !== 3'b000) begin errors++; $display("FAIL reset_overrun got %b exp 000", {ovr_a, ovr_p, ovr_s}); end
    checks++; if ({if_p.valid, if_s.valid} !== 2'b00) begin errors++; $display("FAIL reset_valid_ps got %b exp 00", {if_p.valid, if_s.valid}); end
`ifdef UART_RX_BREAK_DET_EN
    checks++; if (brk_a !== 1'b0) begin errors++; $display("FAIL reset_break got %b exp 0", brk_a); end
`endif
  endtask

  task automatic test_basic;
    send_bits(0, {1'b1, 8'h55, 1'b0}, 10);
    idle(0, 1);
    $display("frame dut_a 55 sent");
    checks++; if (if_a.valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", if_a.valid); end
    checks++; if (if_a.data !== 8'h55) begin errors++; $display("FAIL basic_data got %h exp 55", if_a.data); end
    checks++; if ({if_a.parity_err, if_a.frame_err} !== 2'b00) begin errors++; $display("FAIL basic_errs got %b exp 00", {if_a.parity_err, if_a.frame_err}); end
    checks++; if (if_a.level !== 3'd1) begin errors++; $display("FAIL basic_level1 got %0d exp 1", if_a.level); end
    pop(0);
    checks++; if (if_a.level !== 3'd0) begin errors++; $display("FAIL basic_level0 got %0d exp 0", if_a.level); end
    checks++; if (if_a.valid !== 1'b0) begin errors++; $display("FAIL basic_valid0 got %b exp 0", if_a.valid); end
  endtask

  task automatic test_parity;
    // 0xA3 has four ones, so the correct even parity bit is 0.
    send_bits(1, {1'b1, 1'b1, 8'hA3, 1'b0}, 11);
    idle(1, 1);
    $display("frame dut_p A3 parity=1 sent");
    checks++; if (if_p.data !== 8'hA3) begin errors++; $display("FAIL par_bad_data got %h exp a3", if_p.data); end
    checks++; if ({if_p.parity_err, if_p.frame_err} !== 2'b10) begin errors++; $display("FAIL par_bad_errs got %b exp 10", {if_p.parity_err, if_p.frame_err}); end
    pop(1);
    send_bits(1, {1'b1, 1'b0, 8'hA3, 1'b0}, 11);
    idle(1, 1);
    $display("frame dut_p A3 parity=0 sent");
    checks++; if (if_p.data !== 8'hA3) begin errors++; $display("FAIL par_ok_data got %h exp a3", if_p.data); end
    checks++; if ({if_p.parity_err, if_p.frame_err} !== 2'b00) begin errors++; $display("FAIL par_ok_errs got %b exp 00", {if_p.parity_err, if_p.frame_err}); end
    pop(1);
    checks++; if (if_p.level !== 3'd0) begin errors++; $display("FAIL par_level got %0d exp 0", if_p.level); end
  endtask

  task automatic test_stop;
    send_bits(2, {1'b0, 1'b1, 8'h3C, 1'b0}, 11);
    idle(2, 1);
    $display("frame dut_s 3C stop2=0 sent");
    checks++; if (if_s.data !== 8'h3C) begin errors++; $display("FAIL stop_bad_data got %h exp 3c", if_s.data); end
    checks++; if ({if_s.parity_err, if_s.frame_err} !== 2'b01) begin errors++; $display("FAIL stop_bad_errs got %b exp 01", {if_s.parity_err, if_s.frame_err}); end
    pop(2);
    send_bits(2, {1'b1, 1'b1, 8'hC3, 1'b0}, 11);
    idle(2, 1);
    $display("frame dut_s C3 sent");
    checks++; if (if_s.data !== 8'hC3) begin errors++; $display("FAIL stop_ok_data got %h exp c3", if_s.data); end
    checks++; if (if_s.frame_err !== 1'b0) begin errors++; $display("FAIL stop_ok_ferr got %b exp 0", if_s.frame_err); end
    pop(2);
  endtask

  task automatic test_overrun;
    for (int i = 1; i <= 4; i++) begin
      send_bits(0, {1'b1, 8'(i), 1'b0}, 10);
      $display("frame dut_a %h sent", 8'(i));
    end
    checks++; if (if_a.level !== 3'd4) begin errors++; $display("FAIL ovr_level4 got %0d exp 4", if_a.level); end
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_early got %b exp 0", ovr_a); end
    send_bits(0, {1'b1, 8'h05, 1'b0}, 10);
    idle(0, 1);
    $display("frame dut_a 05 sent");
    checks++; if (if_a.level !== 3'd4) begin errors++; $display("FAIL ovr_level_full got %0d exp 4", if_a.level); end
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", ovr_a); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (if_a.data !== 8'(i)) begin errors++; $display("FAIL ovr_pop_data got %h exp %h", if_a.data, 8'(i)); end
      pop(0);
    end
    checks++; if (if_a.valid !== 1'b0) begin errors++; $display("FAIL ovr_empty got %b exp 0", if_a.valid); end
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", ovr_a); end
    clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", ovr_a); end
  endtask

  task automatic test_glitch;
    set_line(0, 1'b0);
    repeat (2 * CLK_DIV) @(negedge clk);
    idle(0, 12);
    $display("glitch dut_a 2 ticks");
    checks++; if (if_a.valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got %b exp 0", if_a.valid); end
    checks++; if (if_a.level !== 3'd0) begin errors++; $display("FAIL glitch_level got %0d exp 0", if_a.level); end
    send_bits(0, {1'b1, 8'h5A, 1'b0}, 10);
    idle(0, 1);
    $display("frame dut_a 5A sent");
    checks++; if (if_a.data !== 8'h5A) begin errors++; $display("FAIL glitch_next_data got %h exp 5a", if_a.data); end
    pop(0);
  endtask

  task automatic test_reset_midframe;
    send_bits(0, {1'b1, 8'hA5, 1'b0}, 4);
    set_line(0, 1'b0);
    repeat (BIT_CLK / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(0, 12);
    $display("reset dut_a during bit 3");
    checks++; if (if_a.valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", if_a.valid); end
    checks++; if (if_a.level !== 3'd0) begin errors++; $display("FAIL midrst_level got %0d exp 0", if_a.level); end
    send_bits(0, {1'b1, 8'h7E, 1'b0}, 10);
    idle(0, 1);
    $display("frame dut_a 7E sent");
    checks++; if (if_a.data !== 8'h7E) begin errors++; $display("FAIL midrst_data got %h exp 7e", if_a.data); end
    checks++; if ({if_a.parity_err, if_a.frame_err} !== 2'b00) begin errors++; $display("FAIL midrst_errs got %b exp 00", {if_a.parity_err, if_a.frame_err}); end
    pop(0);
    checks++; if (if_a.level !== 3'd0) begin errors++; $display("FAIL midrst_level0 got %0d exp 0", if_a.level); end
  endtask

  task automatic test_break;
`ifdef UART_RX_BREAK_DET_EN
    int brk_start;
    brk_start = brk_cnt;
`endif
    set_line(0, 1'b0);
    repeat (20 * BIT_CLK) @(negedge clk);
    idle(0, 12);
    $display("break dut_a 2 frame times");
`ifdef UART_RX_BREAK_DET_EN
    checks++; if (brk_cnt - brk_start !== 1) begin errors++; $display("FAIL break_pulses got %0d exp 1", brk_cnt - brk_start); end
    checks++; if (if_a.level !== 3'd0) begin errors++; $display("FAIL break_level got %0d exp 0", if_a.level); end
`else
    checks++; if (if_a.level !== 3'd1) begin errors++; $display("FAIL break_level got %0d exp 1", if_a.level); end
    checks++; if (if_a.data !== 8'h00) begin errors++; $display("FAIL break_data got %h exp 00", if_a.data); end
    checks++; if ({if_a.parity_err, if_a.frame_err} !== 2'b01) begin errors++; $display("FAIL break_errs got %b exp 01", {if_a.parity_err, if_a.frame_err}); end
    pop(0);
`endif
    send_bits(0, {1'b1, 8'h81, 1'b0}, 10);
    idle(0, 1);
    $display("frame dut_a 81 sent");
    checks++; if (if_a.data !== 8'h81) begin errors++; $display("FAIL break_next_data got %h exp 81", if_a.data); end
    pop(0);
  endtask

  initial begin
    if_a.ready = 1'b0;
    if_p.ready = 1'b0;
    if_s.ready = 1'b0;
    test_reset();
    idle(0, 2);
    test_basic();
    test_parity();
    test_stop();
    test_overrun();
    test_glitch();
    test_reset_midframe();
    test_break();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
